pipe_scroller: RTL



---
 rtl/flappy_pkg.sv | 33 +++
 rtl/lfsr16.sv | 23 ++
 rtl/pipe_scroller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and score helpers for the flappy game blocks
// (pipe_scroller, obstacle checker, renderer).
package flappy_pkg;

   localparam int NUM_PIPES = 3;
   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int PIPE_W    = 80;
   localparam int PIPE_GAP  = 100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   function automatic logic [7:0] score_inc_bin(input logic [7:0] s);
      logic [7:0] n;
      if (s == 8'hFF) n = s;
      else            n = s + 8'd1;
      return n;
   endfunction

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] score_inc_bcd(input logic [7:0] s);
      logic [7:0] n;
      if (s == 8'h99)           n = s;
      else if (s[3:0] == 4'd9)  n = {s[7:4] + 4'd1, 4'd0};
      else                      n = {s[7:4], s[3:0] + 4'd1};
      return n;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) with a
// synchronous reset to a nonzero seed.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        reset,
   output logic [15:0] value
);

   logic [15:0] q_r;
   logic        fb_s;

   assign fb_s  = q_r[0] ^ q_r[2] ^ q_r[3] ^ q_r[5];
   assign value = q_r;

   // Shift right every clock, feedback enters at the top.
   always_ff @(posedge Clk) begin
      if (reset) q_r <= SEED;
      else       q_r <= {fb_s, q_r[15:1]};
   end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls three pipes, respawns them with random gaps and keeps the score.
// Define SCORE_BCD_EN for a two-digit BCD score (saturates at 99) instead of binary.
module pipe_scroller
   import flappy_pkg::*;
#(
   parameter int          TICK_DIV     = 833333,
   parameter int          SPEED        = 2,
   parameter int          PIPE_W       = flappy_pkg::PIPE_W,
   parameter int          PIPE_SPACING = 240,
   parameter int          PIPE_START   = 400,
   parameter int          GAP_MIN      = 60,
   parameter int          GAP_RANGE    = 240,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        Start,
   input  logic        Ack,
   input  logic        Lose,
   input  logic [9:0]  Bird_X,
   output logic [9:0]  X_Edge,
   output logic [9:0]  Y_Edge,
   output logic [29:0] Pipe_X_All,
   output logic [29:0] Pipe_Y_All,
   output logic [7:0]  Score,
   output logic        Frame_Tick,
   output logic        Q_Idle,
   output logic        Q_Run,
   output logic        Q_Halt
);

   localparam int               CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TICK_DIV - 1);
   localparam logic [9:0]       SPEED_V     = 10'(SPEED);
   localparam logic [9:0]       RESPAWN_ADD = 10'(3 * PIPE_SPACING - SPEED);
   localparam logic [9:0]       GAP_MIN_V   = 10'(GAP_MIN);

   if (PIPE_START + 2 * PIPE_SPACING > 1023) begin : g_bad_start
      $error("pipe_scroller: PIPE_START + 2*PIPE_SPACING exceeds the 10-bit X range");
   end
   if (3 * PIPE_SPACING > 1023) begin : g_bad_spacing
      $error("pipe_scroller: 3*PIPE_SPACING exceeds the 10-bit X range");
   end
   if (SPEED >= PIPE_SPACING) begin : g_bad_speed
      $error("pipe_scroller: SPEED must be smaller than PIPE_SPACING");
   end

   state_t           state_r;
   logic [9:0]       x_r [NUM_PIPES];
   logic [9:0]       y_r [NUM_PIPES];
   logic [1:0]       cur_r;
   logic [7:0]       score_r;
   logic [CNT_W-1:0] cnt_r;
   logic             tick_r;
   logic [15:0]      lfsr_s;
   logic [9:0]       x_cur_s;
   logic [9:0]       y_cur_s;
   logic [10:0]      pass_sum_s;
   logic             pass_s;
   logic [7:0]       score_inc_s;

   // Fold an 8-bit random slice into [GAP_MIN, GAP_MIN + GAP_RANGE - 1].
   function automatic logic [9:0] gap_y(input logic [7:0] r);
      logic [8:0] rr;
      logic [8:0] m;
      rr = {1'b0, r};
      if (rr >= 9'(GAP_RANGE)) m = rr - 9'(GAP_RANGE);
      else                     m = rr;
      return GAP_MIN_V + {1'b0, m};
   endfunction

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .Clk   (Clk),
      .reset (reset),
      .value (lfsr_s)
   );

   // Current-pipe select and the pass test against the bird.
   always_comb begin
      x_cur_s = x_r[0];
      y_cur_s = y_r[0];
      case (cur_r)
         2'd0:    begin x_cur_s = x_r[0]; y_cur_s = y_r[0]; end
         2'd1:    begin x_cur_s = x_r[1]; y_cur_s = y_r[1]; end
         2'd2:    begin x_cur_s = x_r[2]; y_cur_s = y_r[2]; end
         default: begin x_cur_s = x_r[0]; y_cur_s = y_r[0]; end
      endcase
      pass_sum_s = {1'b0, x_cur_s} + 11'(PIPE_W);
      if (pass_sum_s < {1'b0, Bird_X}) pass_s = 1'b1;
      else                             pass_s = 1'b0;
`ifdef SCORE_BCD_EN
      score_inc_s = score_inc_bcd(score_r);
`else
      score_inc_s = score_inc_bin(score_r);
`endif
   end

   // Game FSM, scroll counter, pipe motion and scoring.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_r[i] <= 10'(PIPE_START + i * PIPE_SPACING);
            y_r[i] <= GAP_MIN_V;
         end
         cur_r   <= 2'd0;
         score_r <= 8'd0;
         cnt_r   <= '0;
         tick_r  <= 1'b0;
      end else begin
         tick_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  state_r <= ST_RUN;
                  score_r <= 8'd0;
                  cur_r   <= 2'd0;
                  cnt_r   <= '0;
                  y_r[0]  <= gap_y(lfsr_s[7:0]);
                  y_r[1]  <= gap_y(lfsr_s[11:4]);
                  y_r[2]  <= gap_y(lfsr_s[15:8]);
               end
            end
            ST_RUN: begin
               // Lose beats any tick or pass landing on the same edge.
               if (Lose) begin
                  state_r <= ST_HALT;
               end else begin
                  if (cnt_r == CNT_MAX) begin
                     cnt_r  <= '0;
                     tick_r <= 1'b1;
                     for (int i = 0; i < NUM_PIPES; i++) begin
                        if (x_r[i] < SPEED_V) begin
                           x_r[i] <= x_r[i] + RESPAWN_ADD;
                           y_r[i] <= gap_y(lfsr_s[7:0]);
                        end else begin
                           x_r[i] <= x_r[i] - SPEED_V;
                        end
                     end
                  end else begin
                     cnt_r <= cnt_r + 1'b1;
                  end
                  if (pass_s) begin
                     cur_r   <= (cur_r == 2'd2) ? 2'd0 : cur_r + 2'd1;
                     score_r <= score_inc_s;
                  end
               end
            end
            ST_HALT: begin
               if (Ack) begin
                  state_r <= ST_IDLE;
                  for (int i = 0; i < NUM_PIPES; i++) begin
                     x_r[i] <= 10'(PIPE_START + i * PIPE_SPACING);
                     y_r[i] <= GAP_MIN_V;
                  end
                  cur_r <= 2'd0;
                  cnt_r <= '0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign X_Edge     = x_cur_s;
   assign Y_Edge     = y_cur_s;
   assign Pipe_X_All = {x_r[2], x_r[1], x_r[0]};
   assign Pipe_Y_All = {y_r[2], y_r[1], y_r[0]};
   assign Score      = score_r;
   assign Frame_Tick = tick_r;
   assign Q_Idle     = (state_r == ST_IDLE);
   assign Q_Run      = (state_r == ST_RUN);
   assign Q_Halt     = (state_r == ST_HALT);

endmodule
